// File: rtl/fetch_unit.sv
// fetch_unit -- single-outstanding instruction fetch stage.
//
// Issues one instruction-memory read at a time and holds the returned word
// until downstream consumes it. The PC then advances to the sequential, jump
// or taken-branch target, depending on the decode flags presented with that
// consume handshake.
//
// Optional feature: define FETCH_RETIRE_CNT_EN to add the retire_cnt port and
// its counter of delivered instructions.
//
// Parameters
//   RESET_PC     PC value loaded on reset.
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   imem_req     read request, held until imem_ready
//   imem_addr    byte address of the request (equals pc)
//   imem_ready   memory accepts the request; imem_rdata valid same cycle
//   imem_rdata   instruction word from memory
//   instr        registered instruction for decode
//   instr_valid  instr holds a valid instruction
//   instr_ready  downstream consumes instr this cycle
//   pc           address of current instr / current request
//   pc_plus4     pc + 4 (wrapping)
//   jump         decoded jump, sampled on the consume handshake only
//   branch       decoded branch, sampled on the consume handshake only
//   zero         ALU zero flag, sampled on the consume handshake only
//   retire_cnt   delivered-instruction count (FETCH_RETIRE_CNT_EN only)

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        jump,
  input  logic        branch,
  input  logic        zero
`ifdef FETCH_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_offset;
  logic [31:0] w_next_pc;
  logic        w_accept;
  logic        w_handshake;

  // Next-state and Moore outputs.
  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // imem_ready only counts while a request is outstanding.
  assign w_accept    = imem_req & imem_ready;
  assign w_handshake = instr_valid & instr_ready;

  assign w_pc_plus4  = r_pc + 32'd4;
  assign w_br_offset = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

  // The decode flags feed only this mux, whose result is registered solely on
  // the handshake, so their values in any other cycle have no effect.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (jump) begin
      w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
    end else if (branch && zero) begin
      w_next_pc = w_pc_plus4 + w_br_offset;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_handshake) begin
      r_pc <= w_next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= '0;
    end else if (w_accept) begin
      r_instr <= imem_rdata;
    end
  end

`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] r_retire_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retire_cnt <= '0;
    end else if (w_handshake) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign instr     = r_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances with different RESET_PC values run in
// lockstep on shared stimulus. A transaction-level model predicts every output
// at each falling edge; literal expectations pin key addresses.

module tb_fetch_unit;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'h8000_0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic        jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;

  logic        req [2];
  logic [31:0] addr [2];
  logic [31:0] ins [2];
  logic        vld [2];
  logic [31:0] pcv [2];
  logic [31:0] pp4 [2];
`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] cnt [2];
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req[0]), .imem_addr(addr[0]),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(ins[0]), .instr_valid(vld[0]), .instr_ready(instr_ready),
    .pc(pcv[0]), .pc_plus4(pp4[0]),
    .jump(jump), .branch(branch), .zero(zero)
`ifdef FETCH_RETIRE_CNT_EN
    , .retire_cnt(cnt[0])
`endif
  );

  fetch_unit #(.RESET_PC(RPC1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req[1]), .imem_addr(addr[1]),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr(ins[1]), .instr_valid(vld[1]), .instr_ready(instr_ready),
    .pc(pcv[1]), .pc_plus4(pp4[1]),
    .jump(jump), .branch(branch), .zero(zero)
`ifdef FETCH_RETIRE_CNT_EN
    , .retire_cnt(cnt[1])
`endif
  );

  // ---------------- transaction-level model ----------------
  logic        m_started;
  logic        m_have;
  logic [31:0] m_instr;
  logic [31:0] m_pc [2];
`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] m_cnt;
`endif

  function automatic logic [31:0] target(input logic [31:0] cur, input logic [31:0] iw,
                                         input logic j, input logic b, input logic z);
    logic [31:0] seq;
    int off;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = int'($signed(iw[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_started <= 1'b0;
      m_have    <= 1'b0;
      m_instr   <= '0;
      m_pc[0]   <= RPC0;
      m_pc[1]   <= RPC1;
`ifdef FETCH_RETIRE_CNT_EN
      m_cnt     <= '0;
`endif
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (!m_have) begin
      if (imem_ready) begin
        m_instr <= imem_rdata;
        m_have  <= 1'b1;
      end
    end else if (instr_ready) begin
      m_have  <= 1'b0;
      m_pc[0] <= target(m_pc[0], m_instr, jump, branch, zero);
      m_pc[1] <= target(m_pc[1], m_instr, jump, branch, zero);
`ifdef FETCH_RETIRE_CNT_EN
      m_cnt   <= m_cnt + 32'd1;
`endif
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("imem_req[%0d]", d), 32'(req[d]), 32'(m_started & ~m_have));
      chk($sformatf("instr_valid[%0d]", d), 32'(vld[d]), 32'(m_have));
      chk($sformatf("instr[%0d]", d), ins[d], m_instr);
      chk($sformatf("pc[%0d]", d), pcv[d], m_pc[d]);
      chk($sformatf("imem_addr[%0d]", d), addr[d], m_pc[d]);
      chk($sformatf("pc_plus4[%0d]", d), pp4[d], m_pc[d] + 32'd4);
`ifdef FETCH_RETIRE_CNT_EN
      chk($sformatf("retire_cnt[%0d]", d), cnt[d], m_cnt);
`endif
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  // Enter in REQ just after a tick; leaves in REQ just after the handshake tick.
  // Outside the handshake, decode flags and imem_ready carry junk that must be ignored.
  task automatic fetch_one(input logic [31:0] data, input logic j, input logic b,
                           input logic z, input int unsigned req_stall,
                           input int unsigned hold_stall);
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    jump = 1'b1; branch = 1'b1; zero = 1'b1;
    for (int unsigned i = 0; i < req_stall; i++) tick();
    imem_ready = 1'b1;
    imem_rdata = data;
    tick();
    imem_rdata  = ~data;
    instr_ready = 1'b0;
    for (int unsigned i = 0; i < hold_stall; i++) tick();
    instr_ready = 1'b1;
    jump = j; branch = b; zero = z;
    tick();
    instr_ready = 1'b0;
    imem_ready  = 1'b0;
    jump = 1'b0; branch = 1'b0; zero = 1'b0;
  endtask

  initial begin
    // ---- Phase A: reset, jump priority, stalls, branch taken/not taken ----
    tick();
    tick();
    chk("rst_req", 32'(req[0]), 32'd0);
    chk("rst_valid", 32'(vld[0]), 32'd0);
    chk("rst_instr", ins[0], 32'h0);
    chk("rst_pc0", pcv[0], 32'h0000_0000);
    chk("rst_pc1", pcv[1], 32'h8000_0010);
    rst_n = 1'b1;
    chk("idle_req", 32'(req[0]), 32'd0);
    tick();
    chk("first_req", 32'(req[0]), 32'd1);
    chk("first_addr", addr[0], 32'h0);

    fetch_one(32'h0800_0040, 1'b1, 1'b1, 1'b1, 0, 0);
    chk("jump_addr0", addr[0], 32'h0000_0100);
    chk("jump_addr1", addr[1], 32'h8000_0100);

    fetch_one(32'h1000_FFFF, 1'b0, 1'b1, 1'b1, 3, 5);
    chk("br_taken_addr", addr[0], 32'h0000_0100);

    fetch_one(32'h1000_FFFF, 1'b0, 1'b1, 1'b0, 0, 0);
    chk("br_not_taken_addr0", addr[0], 32'h0000_0104);
    chk("br_not_taken_addr1", addr[1], 32'h8000_0104);

    // ---- Phase B: back-to-back sequential fetch, wrap, retire count ----
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    imem_ready  = 1'b1;
    instr_ready = 1'b1;
    imem_rdata  = 32'h0;
    tick();
    chk("seq_req_a", 32'(req[0]), 32'd1);
    chk("seq_addr_a", addr[0], 32'h0);
    tick();
    chk("seq_valid_a", 32'(vld[0]), 32'd1);
    tick();
    chk("seq_addr_b", addr[0], 32'h4);
    tick();
    tick();
    chk("seq_addr_c", addr[0], 32'h8);

    fetch_one(32'h1000_FFFC, 1'b0, 1'b1, 1'b1, 0, 0);
    chk("neg_br_addr", addr[0], 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pp4[0], 32'h0);
    fetch_one(32'h0, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("wrap_addr", addr[0], 32'h0);
    for (int unsigned k = 0; k < 6; k++) fetch_one(32'h0, 1'b0, 1'b0, 1'b0, 0, 0);
    chk("after_ten_addr", addr[0], 32'h18);
`ifdef FETCH_RETIRE_CNT_EN
    chk("retire_cnt_10", cnt[0], 32'd10);
`endif

    // ---- Phase C: hold stall, then reset mid-HOLD ----
    imem_ready = 1'b1;
    imem_rdata = 32'h2400_1234;
    tick();
    imem_ready  = 1'b0;
    instr_ready = 1'b0;
    for (int unsigned k = 0; k < 5; k++) begin
      tick();
      chk("hold_valid", 32'(vld[0]), 32'd1);
      chk("hold_instr", ins[0], 32'h2400_1234);
      chk("hold_pc", pcv[0], 32'h18);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(vld[0]), 32'd0);
    chk("midrst_req", 32'(req[0]), 32'd0);
    chk("midrst_pc0", pcv[0], 32'h0);
    chk("midrst_pc1", pcv[1], 32'h8000_0010);
    chk("midrst_instr", ins[0], 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
